// File: rtl/sys_ctrl_rx_pkg.sv
// Shared types and constants for the UART receive-side command sequencer.
//   state_t       : frame decoder state encoding
//   CMD_*         : command byte codes that open a frame
//   OPA/OPB_ADDR  : register-file slots that hold ALU operands
package sys_ctrl_rx_pkg;

    localparam int unsigned CMD_W     = 8;
    localparam int unsigned ALU_FUN_W = 4;

    localparam logic [CMD_W-1:0] CMD_WR      = 8'hAA;
    localparam logic [CMD_W-1:0] CMD_RD      = 8'hBB;
    localparam logic [CMD_W-1:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [CMD_W-1:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_ALU_OPA = 3'd4,
        ST_ALU_OPB = 3'd5,
        ST_ALU_FUN = 3'd6
    } state_t;

    // States during which the ALU clock must be running
    function automatic logic is_alu_state(input state_t s);
        return (s == ST_ALU_OPA) || (s == ST_ALU_OPB) || (s == ST_ALU_FUN);
    endfunction

endpackage

// File: rtl/sys_ctrl_rx_frame_timer.sv
// Inter-byte timeout counter for an open command frame.
//   clk, rst_n : clock, async active-low reset
//   run        : frame is open, counter advances
//   clear      : byte accepted this cycle, counter restarts
//   expire     : combinational, counter sits at TO_CYC-1 with no byte arriving
module sys_ctrl_rx_frame_timer #(
    parameter int unsigned TO_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CNT_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             at_limit;

    assign at_limit = (cnt_q == CNT_W'(TO_CYC - 1));
    // An arriving byte beats the timeout in the same cycle
    assign expire   = run && at_limit && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run || clear || at_limit) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sys_ctrl_rx.sv
// Receive-side command sequencer: decodes UART byte frames into register-file
// write/read strobes and ALU execute requests.
//   CLK, RST                       : clock, async active-low reset
//   RX_P_DATA, RX_D_VLD            : received byte and its one-cycle valid
//   PAR_ERR, STP_ERR               : per-byte line errors (qualified by RX_D_VLD)
//   RF_WR_EN, RF_RD_EN, RF_ADDR,
//   RF_WR_DATA                     : register-file access (strobes are pulses)
//   ALU_EN, ALU_FUN, CLK_GATE_EN   : ALU execute pulse, function, clock enable
//   BUSY, CMD_DONE, FRAME_ERR      : frame open / completed / aborted
// Build option: RX_ERR_DROP_EN makes a byte with PAR_ERR/STP_ERR abort the frame.
module sys_ctrl_rx
    import sys_ctrl_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned TO_CYC     = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  PAR_ERR,
    input  logic                  STP_ERR,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  ALU_EN,
    output logic [ALU_FUN_W-1:0]  ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic                  BUSY,
    output logic                  CMD_DONE,
    output logic                  FRAME_ERR
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
    logic [ADDR_WIDTH-1:0] rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_d;
    logic [ALU_FUN_W-1:0]  alu_fun_d;
    logic                  rf_wr_en_d, rf_rd_en_d, alu_en_d, cmd_done_d, frame_err_d;
    logic                  expire;
    logic                  byte_err;
    logic [CMD_W-1:0]      cmd_byte;

    assign cmd_byte = CMD_W'(RX_P_DATA);

`ifdef RX_ERR_DROP_EN
    assign byte_err = PAR_ERR || STP_ERR;
`else
    logic unused_err;
    assign byte_err   = 1'b0;
    assign unused_err = PAR_ERR ^ STP_ERR;
`endif

    sys_ctrl_rx_frame_timer #(
        .TO_CYC (TO_CYC)
    ) u_frame_timer (
        .clk    (CLK),
        .rst_n  (RST),
        .run    (state_q != ST_IDLE),
        .clear  (RX_D_VLD),
        .expire (expire)
    );

    // State and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            addr_lat_q  <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_DATA  <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            BUSY        <= 1'b0;
            CMD_DONE    <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lat_q  <= addr_lat_d;
            RF_WR_EN    <= rf_wr_en_d;
            RF_RD_EN    <= rf_rd_en_d;
            RF_ADDR     <= rf_addr_d;
            RF_WR_DATA  <= rf_wr_data_d;
            ALU_EN      <= alu_en_d;
            ALU_FUN     <= alu_fun_d;
            CLK_GATE_EN <= is_alu_state(state_d) || alu_en_d;
            BUSY        <= (state_d != ST_IDLE);
            CMD_DONE    <= cmd_done_d;
            FRAME_ERR   <= frame_err_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d      = state_q;
        addr_lat_d   = addr_lat_q;
        rf_addr_d    = RF_ADDR;
        rf_wr_data_d = RF_WR_DATA;
        alu_fun_d    = ALU_FUN;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        cmd_done_d   = 1'b0;
        frame_err_d  = 1'b0;

        if (RX_D_VLD) begin
            if (byte_err) begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if      (cmd_byte == CMD_WR)      state_d = ST_WR_ADDR;
                        else if (cmd_byte == CMD_RD)      state_d = ST_RD_ADDR;
                        else if (cmd_byte == CMD_ALU_OP)  state_d = ST_ALU_OPA;
                        else if (cmd_byte == CMD_ALU_NOP) state_d = ST_ALU_FUN;
                    end
                    ST_WR_ADDR: begin
                        addr_lat_d = RX_P_DATA[ADDR_WIDTH-1:0];
                        state_d    = ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        rf_wr_en_d   = 1'b1;
                        cmd_done_d   = 1'b1;
                        rf_addr_d    = addr_lat_q;
                        rf_wr_data_d = RX_P_DATA;
                        state_d      = ST_IDLE;
                    end
                    ST_RD_ADDR: begin
                        rf_rd_en_d = 1'b1;
                        cmd_done_d = 1'b1;
                        rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                        state_d    = ST_IDLE;
                    end
                    ST_ALU_OPA: begin
                        rf_wr_en_d   = 1'b1;
                        rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
                        rf_wr_data_d = RX_P_DATA;
                        state_d      = ST_ALU_OPB;
                    end
                    ST_ALU_OPB: begin
                        rf_wr_en_d   = 1'b1;
                        rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
                        rf_wr_data_d = RX_P_DATA;
                        state_d      = ST_ALU_FUN;
                    end
                    ST_ALU_FUN: begin
                        alu_en_d   = 1'b1;
                        cmd_done_d = 1'b1;
                        alu_fun_d  = RX_P_DATA[ALU_FUN_W-1:0];
                        state_d    = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (expire) begin
            // Abandon the frame; strobes already issued stay issued
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end
    end

endmodule

// File: doc/sys_ctrl_rx.md
# sys_ctrl_rx

Command sequencer on the receive side of the UART link. It consumes the byte stream delivered by the UART receiver (P_DATA / Data_Valid plus the parity and stop flags) and decodes multi-byte command frames. It then drives the register-file write/read strobes, the ALU enable/function and the ALU clock-gate enable. It sits between the UART receiver (synchronised into the system clock domain) and the register file and ALU.

## Interface
- DATA_WIDTH, 8, width of received bytes and register-file data
- ADDR_WIDTH, 4, register-file address width; the address is taken from the low bits of the address byte
- TO_CYC, 4096, inter-byte timeout in CLK cycles while a frame is open; must be ≥2
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte, valid only when RX_D_VLD=1
- RX_D_VLD  in  1  single-cycle pulse per received byte
- PAR_ERR  in  1  parity error for the current byte, qualified by RX_D_VLD
- STP_ERR  in  1  stop error for the current byte, qualified by RX_D_VLD
- RF_WR_EN  out  1  register-file write strobe, one-cycle pulse
- RF_RD_EN  out  1  register-file read strobe, one-cycle pulse
- RF_ADDR  out  ADDR_WIDTH  register-file address, held until the next strobe
- RF_WR_DATA  out  DATA_WIDTH  write data, held until the next write
- ALU_EN  out  1  ALU execute, one-cycle pulse
- ALU_FUN  out  4  ALU function, held until the next ALU_EN
- CLK_GATE_EN  out  1  ALU clock enable
- BUSY  out  1  a frame is open (state is not IDLE)
- CMD_DONE  out  1  one-cycle pulse when a frame completes successfully
- FRAME_ERR  out  1  one-cycle pulse when a frame is aborted

## Operation
- Command bytes are accepted only in IDLE:
  - 0xAA: write, frame AA, addr, data
  - 0xBB: read, frame BB, addr
  - 0xCC: ALU with operands, frame CC, opA, opB, fun
  - 0xDD: ALU without operands, frame DD, fun
- Any other byte in IDLE is ignored. There is no FRAME_ERR pulse for it.
- FSM states and transitions, all advanced by an accepted RX_D_VLD byte:
  - IDLE → WR_ADDR, RD_ADDR, ALU_OPA or ALU_FUN according to the command byte
  - WR_ADDR → WR_DATA. The address is latched here.
  - WR_DATA → IDLE. Pulses RF_WR_EN with the latched address and this data byte.
  - RD_ADDR → IDLE. Pulses RF_RD_EN.
  - ALU_OPA → ALU_OPB. Writes opA to address 0 (RF_WR_EN pulse).
  - ALU_OPB → ALU_FUN. Writes opB to address 1 (RF_WR_EN pulse).
  - ALU_FUN → IDLE. Pulses ALU_EN with ALU_FUN = byte[3:0].
- CMD_DONE pulses together with the final strobe of each frame (RF_WR_EN, RF_RD_EN or ALU_EN).
- CLK_GATE_EN is 1 whenever the state is ALU_OPA, ALU_OPB or ALU_FUN, and during the ALU_EN cycle. It is 0 otherwise.
- Timeout:
  - A cycle counter runs only when the state is not IDLE. It is cleared on every accepted byte.
  - When the counter reaches TO_CYC−1, the FSM returns to IDLE and FRAME_ERR pulses.
  - No strobe is issued for the aborted frame. Strobes already issued for completed bytes (e.g. opA) are not undone.
- If RX_D_VLD arrives in the same cycle the timeout would fire, the byte wins: it is processed and the counter clears.
- A command-code value that arrives mid-frame is treated as data (no resynchronisation).

## Timing
- All outputs are registered.
- A strobe, CMD_DONE or FRAME_ERR pulse appears exactly one cycle after the RX_D_VLD (or timeout) cycle.
- The state changes on the same edge as that pulse.
- RX_D_VLD spacing can be one cycle: back-to-back bytes are accepted on consecutive cycles.
- Reset values:
  - all strobes, ALU_EN, CLK_GATE_EN, BUSY, CMD_DONE and FRAME_ERR are 0
  - RF_ADDR, RF_WR_DATA and ALU_FUN are 0
  - state is IDLE and the counter is 0
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). After release, the next accepted byte is treated as a command.

## Configuration
- RX_ERR_DROP_EN defined:
  - an accepted byte with PAR_ERR or STP_ERR set aborts the open frame
  - the FSM goes to IDLE, FRAME_ERR pulses and no strobe is issued
  - an erroneous command byte in IDLE is ignored and pulses FRAME_ERR
- RX_ERR_DROP_EN undefined:
  - PAR_ERR and STP_ERR are ignored
  - FRAME_ERR pulses on timeout only

## Structure
- Shared package holds:
  - the state encoding type
  - the command codes CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD
  - the operand addresses OPA_ADDR=0 and OPB_ADDR=1
- One sub-module, frame_timer: the timeout counter, with inputs run and clear and output expire.

## Test plan
- Bytes AA, 05, 3C → RF_WR_EN pulses once with RF_ADDR=5 and RF_WR_DATA=0x3C, CMD_DONE pulses in the same cycle, BUSY falls.
- Bytes BB, 0A → one RF_RD_EN pulse with RF_ADDR=0xA, no RF_WR_EN.
- Bytes CC, 12, 34, 01 → writes (0,0x12), then (1,0x34), then ALU_EN with ALU_FUN=1. CLK_GATE_EN is high from the cycle after CC through the ALU_EN cycle.
- Bytes DD, 07 → ALU_EN with ALU_FUN=7. Bytes 55 and 0x00 in IDLE produce no response.
- Byte AA, then idle for TO_CYC cycles → FRAME_ERR pulse, BUSY=0. The following bytes BB, 02 decode as a read.
- With RX_ERR_DROP_EN, bytes AA, 05 (PAR_ERR=1) → FRAME_ERR, no RF_WR_EN. Without the macro, the same stimulus plus a data byte writes normally.
